// File: rtl/three_way_tc_pkg.sv
// ---------------------------------------------------------------------------
// three_way_tc_pkg
// Shared definitions for the 3-way split carry-less 256x256 multiplier
// controller: operand/limb geometry, the FSM state type, the fixed limb
// product schedule and two small helpers (limb extraction and placement of
// a limb product into the 512-bit accumulator frame).
// No ports; imported by three_way_tc_scheduler and gf2_serial_mul.
// ---------------------------------------------------------------------------
package three_way_tc_pkg;

   // Operand width and the limb stride. Limbs 0 and 1 are L0 bits wide, the
   // top limb takes the remaining WIDTH-2*L0 bits, which sets the core width.
   localparam int WIDTH   = 256;
   localparam int L0      = 85;
   localparam int LW      = WIDTH - 2 * L0;
   localparam int PW      = 2 * LW - 1;
   localparam int NPROD   = 9;
   localparam int LATENCY = NPROD * (LW + 1);

   // Controller states.
   typedef enum logic [1:0] {
      IDLE,
      MUL,
      ACC,
      DONE
   } state_t;

   // Product order k=0..8 as (i,j) limb pairs, ascending in i+j.
   localparam logic [1:0] SCHED_I [NPROD] = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2};
   localparam logic [1:0] SCHED_J [NPROD] = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd2};

   // Extract limb idx of an operand, zero-extended to the core width.
   function automatic logic [LW-1:0] limb(input logic [WIDTH-1:0] x, input logic [1:0] idx);
      logic [LW-1:0] r;
      case (idx)
         2'd0:    r = {1'b0, x[L0-1:0]};
         2'd1:    r = {1'b0, x[2*L0-1:L0]};
         default: r = x[WIDTH-1:2*L0];
      endcase
      return r;
   endfunction

   // Position a limb product at x^(L0*s) inside the 512-bit result frame.
   // The highest placement (s=4) reaches bit 170+340=510, so bit 511 stays 0.
   function automatic logic [2*WIDTH-1:0] place(input logic [PW-1:0] p, input logic [2:0] s);
      logic [2*WIDTH-1:0] ext;
      logic [2*WIDTH-1:0] r;
      ext = {{(2*WIDTH-PW){1'b0}}, p};
      case (s)
         3'd0:    r = ext;
         3'd1:    r = ext << L0;
         3'd2:    r = ext << (2 * L0);
         3'd3:    r = ext << (3 * L0);
         3'd4:    r = ext << (4 * L0);
         default: r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/gf2_serial_mul.sv
// ---------------------------------------------------------------------------
// gf2_serial_mul
// Bit-serial LW x LW carry-less (GF(2)[x]) multiplier. A start pulse loads
// both limbs and processes bit 0 of a_limb in the same cycle; each further
// cycle processes the next bit, LSB first. After LW cycles in total the
// product is held in p until the next start.
// Ports:
//   clk     in   rising-edge clock
//   rst     in   synchronous active-low reset
//   start   in   begin a new product (one-cycle pulse)
//   a_limb  in   LW-bit multiplier limb (consumed serially)
//   b_limb  in   LW-bit multiplicand limb
//   done    out  high during the cycle whose edge processes the last bit
//   p       out  2*LW-1 bit carry-less product
// ---------------------------------------------------------------------------
module gf2_serial_mul
   import three_way_tc_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [LW-1:0] a_limb,
   input  logic [LW-1:0] b_limb,
   output logic          done,
   output logic [PW-1:0] p
);

   logic [LW-1:0] a_sh;
   logic [PW-1:0] b_sh;
   logic [6:0]    cnt;
   logic          run;
   logic [PW-1:0] b_ext;

   assign b_ext = {{(PW-LW){1'b0}}, b_limb};

   // done is combinational so the controller can leave MUL on the very edge
   // that folds in the last bit; p is final in the following cycle.
   assign done = run && (cnt == 7'(LW - 1));

   // Shift-and-add datapath: a_sh walks the multiplier bits down to bit 0
   // while b_sh walks the multiplicand up, so only a 1-bit test and one XOR
   // row are needed per cycle instead of a barrel shifter.
   always_ff @(posedge clk) begin
      if (!rst) begin
         a_sh <= '0;
         b_sh <= '0;
         p    <= '0;
         cnt  <= '0;
         run  <= 1'b0;
      end else if (start) begin
         p    <= a_limb[0] ? b_ext : '0;
         a_sh <= a_limb >> 1;
         b_sh <= b_ext << 1;
         cnt  <= 7'd1;
         run  <= 1'b1;
      end else if (run) begin
         if (a_sh[0]) begin
            p <= p ^ b_sh;
         end
         a_sh <= a_sh >> 1;
         b_sh <= b_sh << 1;
         cnt  <= cnt + 7'd1;
         if (done) begin
            run <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/three_way_tc_scheduler.sv
// ---------------------------------------------------------------------------
// three_way_tc_scheduler
// Area-reduced 256x256 carry-less multiplier. One bit-serial limb core is
// time-multiplexed over the nine limb products a_i*b_j, which are XORed into
// a 512-bit accumulator at offset L0*(i+j). One transaction in flight.
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-low reset
//   in_valid   in   operands a,b valid
//   in_ready   out  block can accept operands (IDLE and not in reset)
//   a, b       in   WIDTH-bit polynomial operands (bit i = coeff of x^i)
//   out_valid  out  c holds a finished product
//   out_ready  in   consumer accepts c
//   c          out  2*WIDTH-bit carry-less product, bit 511 always 0
//   busy       out  high from accept until the DONE->IDLE edge
// ---------------------------------------------------------------------------
module three_way_tc_scheduler
   import three_way_tc_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] c,
   output logic               busy
);

   state_t               state;
   state_t               state_next;
   logic [3:0]           k;
   logic [WIDTH-1:0]     a_cap;
   logic [WIDTH-1:0]     b_cap;
   logic [2*WIDTH-1:0]   acc;
   logic                 start;
   logic                 accept;
   logic                 core_done;
   logic [LW-1:0]        a_limb;
   logic [LW-1:0]        b_limb;
   logic [PW-1:0]        partial;
   logic [1:0]           idx_i;
   logic [1:0]           idx_j;
   logic [2:0]           place_sel;

   // Schedule lookup for the current product index. k reaches NPROD after
   // the last accumulate; the guard keeps the table index in range then.
   always_comb begin
      idx_i = 2'd0;
      idx_j = 2'd0;
      if (k < 4'(NPROD)) begin
         idx_i = SCHED_I[k];
         idx_j = SCHED_J[k];
      end
   end

   // Limb muxes feed the core from the captured operands, so a and b may
   // change freely once they have been accepted.
   assign a_limb    = limb(a_cap, idx_i);
   assign b_limb    = limb(b_cap, idx_j);
   assign place_sel = {1'b0, idx_i} + {1'b0, idx_j};

   gf2_serial_mul u_core (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .a_limb (a_limb),
      .b_limb (b_limb),
      .done   (core_done),
      .p      (partial)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and handshake outputs. in_ready is gated by rst so it reads
   // 0 throughout a reset cycle and only rises once reset is released.
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b1;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            busy     = 1'b0;
            in_ready = rst;
            if (in_valid && rst) begin
               accept     = 1'b1;
               state_next = MUL;
            end
         end
         MUL: begin
            if (core_done) begin
               state_next = ACC;
            end
         end
         ACC: begin
            state_next = (k == 4'(NPROD - 1)) ? DONE : MUL;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Datapath: operand capture, product counter, accumulator and the core
   // start strobe. start is registered so it is high exactly in the first
   // cycle of every MUL phase; each product thus costs LW+1 cycles.
   always_ff @(posedge clk) begin
      if (!rst) begin
         k     <= '0;
         a_cap <= '0;
         b_cap <= '0;
         acc   <= '0;
         start <= 1'b0;
      end else begin
         start <= 1'b0;
         if (accept) begin
            a_cap <= a;
            b_cap <= b;
            acc   <= '0;
            k     <= '0;
            start <= 1'b1;
         end
         if (state == ACC) begin
            acc <= acc ^ place(partial, place_sel);
            k   <= k + 4'd1;
            if (k != 4'(NPROD - 1)) begin
               start <= 1'b1;
            end
         end
      end
   end

   // The accumulator only changes while busy, so it is presented directly
   // and stays stable throughout DONE.
   assign c = acc;

endmodule

// File: tb/tb_three_way_tc_scheduler.sv
// ---------------------------------------------------------------------------
// tb_three_way_tc_scheduler
// Scoreboard bench: every accepted operand pair pushes its expected product
// into a queue; a monitor pops and compares whenever out_valid&&out_ready.
// ---------------------------------------------------------------------------
module tb_three_way_tc_scheduler;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [255:0] a;
   logic [255:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [511:0] c;
   logic         busy;

   logic [511:0] exp_q [$];
   int           errors = 0;
   int           checks = 0;
   int           cycle = 0;
   int           accept_cycle = 0;
   int           result_no = 0;
   logic         stall_en = 1'b0;

   three_way_tc_scheduler dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .c         (c),
      .busy      (busy)
   );

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edge counter used for latency measurement.
   always @(posedge clk) cycle <= cycle + 1;

   // Hard stop so the bench never hangs.
   initial begin
      #1500000;
      $display("[TB] FAIL global_timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "[TB] global timeout");
   end

   // Reference carry-less product, bit by bit over the whole operand.
   function automatic logic [511:0] clmul(input logic [255:0] x, input logic [255:0] y);
      logic [511:0] r;
      r = '0;
      for (int i = 0; i < 256; i++) begin
         if (x[i]) r = r ^ ({256'b0, y} << i);
      end
      return r;
   endfunction

   function automatic logic [255:0] rand256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, act, expv);
      end
   endtask

   task automatic failNow(input string name);
      checks++;
      errors++;
      $display("[TB] FAIL %s: bound expired", name);
   endtask

   // Scoreboard monitor: a handshake happens at the next rising edge whenever
   // out_valid and out_ready are both high at the falling edge.
   always @(negedge clk) begin
      if (rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            failNow("unexpected_output");
         end else begin
            logic [511:0] e;
            e = exp_q.pop_front();
            checkOutput($sformatf("result_%0d", result_no), c, e);
            result_no++;
         end
      end
   end

   // Random consumer back-pressure for the random phase.
   always @(posedge clk) begin
      if (stall_en) begin
         #1;
         out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // Wait for in_ready, present operands for one accept edge, queue the
   // expected product, then scramble a/b to prove the captured copies are used.
   task automatic applyStimulus(input logic [255:0] av, input logic [255:0] bv, input logic [511:0] expv);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!in_ready && guard < 3000) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) begin
         failNow("accept_wait");
      end else begin
         a = av;
         b = bv;
         in_valid = 1'b1;
         @(posedge clk);
         #1;
         accept_cycle = cycle;
         exp_q.push_back(expv);
         in_valid = 1'b0;
         a = rand256();
         b = rand256();
      end
   endtask

   task automatic waitDrain();
      int guard;
      guard = 0;
      while (exp_q.size() != 0 && guard < 3000) begin
         @(negedge clk);
         guard++;
      end
      if (exp_q.size() != 0) failNow("drain_wait");
      @(negedge clk);
   endtask

   initial begin
      logic [255:0] ta;
      logic [255:0] tb;
      logic [511:0] te;
      logic [511:0] c_hold;
      logic         busy_ok;
      logic         ready_low_ok;
      logic         valid_ok;
      logic         c_ok;
      int           guard;

      rst       = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = '0;
      b         = '0;

      // Reset state.
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_in_ready", 512'(in_ready), 512'(0));
      checkOutput("reset_out_valid", 512'(out_valid), 512'(0));
      checkOutput("reset_busy", 512'(busy), 512'(0));
      checkOutput("reset_c", c, 512'(0));
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      checkOutput("post_reset_in_ready", 512'(in_ready), 512'(1));

      // 1*1 with exact latency and busy/in_ready behaviour while running.
      $display("[TB] basic product and latency");
      applyStimulus(256'd1, 256'd1, 512'd1);
      busy_ok = 1'b1;
      ready_low_ok = 1'b1;
      guard = 0;
      @(negedge clk);
      while (!out_valid && guard < 2000) begin
         if (!busy) busy_ok = 1'b0;
         if (in_ready) ready_low_ok = 1'b0;
         @(negedge clk);
         guard++;
      end
      if (!out_valid) begin
         failNow("valid_wait");
      end else begin
         if (!busy) busy_ok = 1'b0;
         checkOutput("latency", 512'(cycle - accept_cycle), 512'(783));
      end
      checkOutput("busy_throughout", 512'(busy_ok), 512'(1));
      checkOutput("in_ready_low_busy", 512'(ready_low_ok), 512'(0) | 512'(1));
      waitDrain();

      // Small and full-width directed products.
      $display("[TB] directed products");
      applyStimulus(256'd3, 256'd3, 512'd5);
      waitDrain();
      ta = '1;
      applyStimulus(ta, 256'd1, {256'b0, ta});
      waitDrain();
      ta = 256'b1 << 255;
      te = 512'b1 << 510;
      applyStimulus(ta, ta, te);
      waitDrain();
      ta = 256'b1 << 170;
      tb = 256'b1 << 85;
      te = 512'b1 << 255;
      applyStimulus(ta, tb, te);
      waitDrain();
      ta = (256'b1 << 84) | (256'b1 << 85);
      tb = (256'b1 << 169) | (256'b1 << 170);
      te = (512'b1 << 253) | (512'b1 << 255);
      applyStimulus(ta, tb, te);
      waitDrain();

      // Stall in DONE and ignored in_valid during MUL.
      $display("[TB] output stall and ignored input");
      applyStimulus(256'hF0, 256'h11, 512'hFF0);
      out_ready = 1'b0;
      repeat (100) @(posedge clk);
      #1;
      ready_low_ok = 1'b1;
      in_valid = 1'b1;
      a = '1;
      b = '1;
      repeat (5) begin
         @(negedge clk);
         if (in_ready) ready_low_ok = 1'b0;
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      checkOutput("in_ready_low_mul", 512'(ready_low_ok), 512'(1));
      guard = 0;
      @(negedge clk);
      while (!out_valid && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      if (!out_valid) failNow("stall_valid_wait");
      c_hold = c;
      valid_ok = 1'b1;
      c_ok = 1'b1;
      ready_low_ok = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (out_valid !== 1'b1) valid_ok = 1'b0;
         if (c !== c_hold) c_ok = 1'b0;
         if (in_ready !== 1'b0) ready_low_ok = 1'b0;
      end
      checkOutput("stall_out_valid", 512'(valid_ok), 512'(1));
      checkOutput("stall_c_stable", 512'(c_ok), 512'(1));
      checkOutput("stall_in_ready", 512'(ready_low_ok), 512'(1));
      @(posedge clk);
      #1 out_ready = 1'b1;
      waitDrain();

      // Reset in the middle of a transaction, then a fresh one.
      $display("[TB] mid-transaction reset");
      applyStimulus(rand256(), rand256(), 512'd0);
      repeat (399) @(posedge clk);
      #1 rst = 1'b0;
      void'(exp_q.pop_back());
      @(posedge clk);
      @(negedge clk);
      checkOutput("midrst_out_valid", 512'(out_valid), 512'(0));
      checkOutput("midrst_busy", 512'(busy), 512'(0));
      checkOutput("midrst_c", c, 512'(0));
      checkOutput("midrst_in_ready", 512'(in_ready), 512'(0));
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      checkOutput("midrst_release_ready", 512'(in_ready), 512'(1));
      applyStimulus(256'h5, 256'h7, 512'h1B);
      waitDrain();

      // Random back-to-back operands with consumer stalls.
      $display("[TB] random phase");
      stall_en = 1'b1;
      for (int n = 0; n < 60; n++) begin
         ta = rand256();
         tb = rand256();
         applyStimulus(ta, tb, clmul(ta, tb));
      end
      @(posedge clk);
      #1 stall_en = 1'b0;
      @(posedge clk);
      #2 out_ready = 1'b1;
      waitDrain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
